// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory responder and its program loader.
package cpu_mem_pkg;
  localparam int AW_DEF = 8;
  localparam int IW_DEF = 16;
  localparam int DW_DEF = 8;
  // A length byte of zero loads the whole instruction store.
  localparam bit LEN_ZERO_FULL = 1'b1;

  typedef enum logic [2:0] {LEN, HI, LO, RUN, CLR} ld_state_e;
endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: length byte, then {hi,lo} instruction words; holds the CPU
// in reset until the last word lands. DMEM_CLEAR_EN adds a data-memory clear pass after LEN.
module program_loader
  import cpu_mem_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid_i,
  input  logic [7:0]    ld_data_i,
  output logic          ld_ready_o,
  input  logic          ld_start_i,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_addr_o,
  output logic [15:0]   imem_wdata_o,
  output logic          dclr_we_o,
  output logic [AW-1:0] dclr_addr_o,
  output logic          cpu_reset_o,
  output logic          ld_done_o
);
  ld_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, idx_q, idx_d, clr_q, clr_d;
  logic [7:0]    hi_q, hi_d;
  logic          cpu_reset_q, ld_done_q, xfer, last_w;

  assign ld_ready_o   = rst_n && (state_q == LEN || state_q == HI || state_q == LO);
  assign xfer         = ld_valid_i && ld_ready_o;
  // cnt_q of zero wraps to all-ones here, which is exactly the full-depth case.
  assign last_w       = (idx_q == cnt_q - AW'(1));
  assign imem_addr_o  = idx_q;
  assign imem_wdata_o = {hi_q, ld_data_i};
  assign dclr_addr_o  = clr_q;
  assign cpu_reset_o  = cpu_reset_q;
  assign ld_done_o    = ld_done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    hi_d      = hi_q;
    clr_d     = clr_q;
    imem_we_o = 1'b0;
    dclr_we_o = 1'b0;
    case (state_q)
      LEN: if (xfer) begin
        cnt_d = AW'(ld_data_i);
        idx_d = '0;
        clr_d = '0;
`ifdef DMEM_CLEAR_EN
        state_d = CLR;
`else
        state_d = HI;
`endif
      end
      HI: if (xfer) begin
        hi_d    = ld_data_i;
        state_d = LO;
      end
      LO: if (xfer) begin
        imem_we_o = 1'b1;
        idx_d     = idx_q + AW'(1);
        state_d   = last_w ? RUN : HI;
      end
      RUN: if (ld_start_i) state_d = LEN;
`ifdef DMEM_CLEAR_EN
      CLR: begin
        dclr_we_o = 1'b1;
        clr_d     = clr_q + AW'(1);
        if (clr_q == '1) state_d = HI;
      end
`endif
      default: state_d = LEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LEN;
      cnt_q       <= '0;
      idx_q       <= '0;
      hi_q        <= '0;
      clr_q       <= '0;
      cpu_reset_q <= 1'b1;
      ld_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      hi_q        <= hi_d;
      clr_q       <= clr_d;
      // Registered off the next state so both flip in the first RUN cycle.
      cpu_reset_q <= (state_d != RUN);
      ld_done_q   <= (state_d == RUN);
    end
  end
endmodule

// File: rtl/cpu_mem_system.sv
// Instruction and data stores for the single-cycle CPU with combinational reads,
// gated to zero until the loader reaches RUN. Optional feature macro: DMEM_CLEAR_EN.
module cpu_mem_system
  import cpu_mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] PC,
  output logic [IW-1:0] IR,
  input  logic [AW-1:0] Address,
  input  logic [DW-1:0] Data_wr,
  input  logic          MW,
  output logic [DW-1:0] Data_rd,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  input  logic          ld_start,
  output logic          cpu_reset,
  output logic          ld_done
);
  logic [IW-1:0] imem [2**AW];
  logic [DW-1:0] dmem [2**AW];
  logic          imem_we, dclr_we;
  logic [AW-1:0] imem_addr, dclr_addr;
  logic [15:0]   imem_wdata;

  program_loader #(.AW(AW)) u_loader (
    .clk          (clk),
    .rst_n        (reset),
    .ld_valid_i   (ld_valid),
    .ld_data_i    (ld_data),
    .ld_ready_o   (ld_ready),
    .ld_start_i   (ld_start),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .dclr_we_o    (dclr_we),
    .dclr_addr_o  (dclr_addr),
    .cpu_reset_o  (cpu_reset),
    .ld_done_o    (ld_done)
  );

  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_addr] <= IW'(imem_wdata);
  end

  // ld_done is high exactly in RUN, so it qualifies CPU stores.
  always_ff @(posedge clk) begin
    if (dclr_we)          dmem[dclr_addr] <= '0;
    else if (MW && ld_done) dmem[Address] <= Data_wr;
  end

  assign IR      = ld_done ? imem[PC]      : '0;
  assign Data_rd = ld_done ? dmem[Address] : '0;
endmodule

// File: tb/tb_cpu_mem_system.sv
// Randomized bench for cpu_mem_system against a byte-counting reference model.
module tb_cpu_mem_system;
  logic        clk = 1'b0;
  logic        reset, MW, ld_valid, ld_start;
  logic [7:0]  PC, Address, Data_wr, ld_data, Data_rd;
  logic [15:0] IR;
  logic        ld_ready, cpu_reset, ld_done;

  cpu_mem_system dut (
    .clk(clk), .reset(reset), .PC(PC), .IR(IR), .Address(Address), .Data_wr(Data_wr),
    .MW(MW), .Data_rd(Data_rd), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_start(ld_start), .cpu_reset(cpu_reset), .ld_done(ld_done)
  );

  always #5 clk = ~clk;

  int nerr = 0, nchk = 0;
  bit go = 0, en_mw = 0;

  // Model: running flag, bytes received in this load, word count, pending clear cycles.
  int m_imem[256], m_dmem[256];
  bit m_run;
  int m_pos, m_n, m_hi, m_clr;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return (reset === 1'b1) && !m_run && (m_clr == 0);
  endfunction

  always @(negedge clk) if (go) begin
    chk("ld_ready", ld_ready, exp_ready());
    chk("cpu_reset", cpu_reset, !m_run);
    chk("ld_done", ld_done, m_run);
    if (m_run) begin
      if (m_imem[PC] >= 0)      chk("IR", IR, m_imem[PC]);
      if (m_dmem[Address] >= 0) chk("Data_rd", Data_rd, m_dmem[Address]);
    end else begin
      chk("IR_gated", IR, 0);
      chk("Data_rd_gated", Data_rd, 0);
    end
  end

  task automatic model_edge();
    int w;
    if (reset !== 1'b1) return;
    if (m_run) begin
      if (MW) m_dmem[Address] = Data_wr;
      if (ld_start) begin m_run = 0; m_pos = 0; end
    end else if (m_clr > 0) begin
      m_dmem[256 - m_clr] = 0;
      m_clr--;
    end else if (ld_valid) begin
      if (m_pos == 0) begin
        m_n = (ld_data == 0) ? 256 : int'(ld_data);
        m_pos = 1;
`ifdef DMEM_CLEAR_EN
        m_clr = 256;
`endif
      end else if (m_pos % 2 == 1) begin
        m_hi = ld_data;
        m_pos++;
      end else begin
        w = (m_pos - 2) / 2;
        m_imem[w] = m_hi * 256 + int'(ld_data);
        m_pos++;
        if (w == m_n - 1) m_run = 1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rnd_cpu();
    PC = 8'($urandom); Address = 8'($urandom); Data_wr = 8'($urandom);
    MW = (en_mw || !m_run) ? ($urandom_range(0, 3) == 0) : 1'b0;
    ld_start = 1'b0;
  endtask

  task automatic do_reset(int k);
    reset = 1'b0;
    m_run = 0; m_pos = 0; m_clr = 0;
    repeat (k) begin rnd_cpu(); cyc(); end
    reset = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int waited);
    waited = 0;
    repeat (gap) begin ld_valid = 1'b0; ld_data = 8'($urandom); rnd_cpu(); cyc(); end
    ld_valid = 1'b1; ld_data = b;
    while (!exp_ready() && waited < 2000) begin rnd_cpu(); cyc(); waited++; end
    if (waited >= 2000) chk("ready_timeout", 0, 1);
    rnd_cpu(); cyc();
  endtask

  task automatic send(input logic [7:0] b);
    int wt;
    send_byte(b, 0, wt);
  endtask

  task automatic kick();
    ld_valid = 1'b0; rnd_cpu(); ld_start = 1'b1; cyc(); ld_start = 1'b0;
  endtask

  task automatic load_rand(int n, int gmax);
    int wt;
    send_byte(8'(n), $urandom_range(0, gmax), wt);
    for (int i = 0; i < 2 * n; i++) send_byte(8'($urandom), $urandom_range(0, gmax), wt);
  endtask

  initial begin
    int wt;
    logic [7:0] b, h255, l255;
    for (int i = 0; i < 256; i++) begin m_imem[i] = -1; m_dmem[i] = -1; end
    m_run = 0; m_pos = 0; m_clr = 0; m_n = 0; m_hi = 0;
    reset = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_start = 1'b0;
    PC = '0; Address = '0; Data_wr = '0; MW = 1'b0;
    go = 1;
    repeat (3) begin rnd_cpu(); cyc(); end
    reset = 1'b1;
    #1;
    chk("rst_cpu_reset", cpu_reset, 1); chk("rst_ld_ready", ld_ready, 1); chk("rst_ld_done", ld_done, 0);

    // Program load with ld_valid held high.
    send(8'h03); send(8'h98); send(8'h41); send(8'h04); send(8'h0A); send(8'hE0); send(8'h00);
    chk("cpu_reset_fall", cpu_reset, 0); chk("ld_done_run", ld_done, 1);
    MW = 1'b0;
    PC = 8'd1; #1 chk("IR_pc1", IR, 16'h040A);
    PC = 8'd0; #1 chk("IR_pc0", IR, 16'h9841);
    PC = 8'd2; #1 chk("IR_pc2", IR, 16'hE000);

    // Handshake stall between HI and LO.
    kick();
    chk("start_cpu_reset", cpu_reset, 1); chk("start_ld_ready", ld_ready, 1);
    send(8'h02); send(8'h11); send(8'h22); send(8'h33);
    send_byte(8'h44, 5, wt);
    MW = 1'b0; PC = 8'd1; #1 chk("IR_stall", IR, 16'h3344);

    // Data path: old value during write cycle, new value after.
    rnd_cpu(); MW = 1'b1; Address = 8'h10; Data_wr = 8'hA5; cyc();
    MW = 1'b0; #1 chk("dmem_write", Data_rd, 8'hA5);
    kick();
    repeat (3) begin rnd_cpu(); MW = 1'b1; Address = 8'h10; Data_wr = 8'h5A; cyc(); end
    send(8'h01); send(8'h12); send(8'h12);
    MW = 1'b0; Address = 8'h10;
`ifdef DMEM_CLEAR_EN
    #1 chk("dmem_len_ignored", Data_rd, 8'h00);
`else
    #1 chk("dmem_len_ignored", Data_rd, 8'hA5);
`endif

    // Reset mid-load, then a one-word reload.
    kick();
    send(8'h03); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    do_reset(3);
    send(8'h01); send(8'hBE); send(8'hEF);
    MW = 1'b0;
    PC = 8'd0; #1 chk("IR_reload0", IR, 16'hBEEF);
    PC = 8'd1; #1 chk("IR_kept1", IR, 16'h5678);
    PC = 8'd2; #1 chk("IR_kept2", IR, 16'hE000);

    // Full-depth load.
    kick();
    send_byte(8'h00, $urandom_range(0, 1), wt);
    for (int i = 0; i < 512; i++) begin
      b = 8'($urandom);
      if (i == 510) h255 = b;
      if (i == 511) l255 = b;
      send_byte(b, $urandom_range(0, 1), wt);
    end
    MW = 1'b0; PC = 8'd255; #1 chk("IR_255", IR, {h255, l255});
    kick();
    chk("reload_cpu_reset", cpu_reset, 1); chk("reload_ld_ready", ld_ready, 1);
    send(8'h01); send(8'hC0); send(8'hDE);
    MW = 1'b0; PC = 8'd0; #1 chk("IR_wrap0", IR, 16'hC0DE);

    // Data-memory clear on reload.
    rnd_cpu(); MW = 1'b1; Address = 8'h07; Data_wr = 8'h33; cyc();
    kick();
    send(8'h01);
    send_byte(8'h00, 0, wt);
`ifdef DMEM_CLEAR_EN
    chk("clr_stall_cycles", wt, 256);
`else
    chk("clr_stall_cycles", wt, 0);
`endif
    send(8'h01);
    MW = 1'b0; Address = 8'h07;
`ifdef DMEM_CLEAR_EN
    #1 chk("dmem7_after_reload", Data_rd, 8'h00);
`else
    #1 chk("dmem7_after_reload", Data_rd, 8'h33);
`endif

    // Randomized reloads, CPU traffic and occasional mid-load resets.
    en_mw = 1;
    for (int it = 0; it < 8; it++) begin
      if (m_run) kick();
      if (it % 3 == 2) begin
        send(8'h05); send(8'($urandom)); send(8'($urandom)); send(8'($urandom));
        do_reset($urandom_range(1, 3));
      end
      load_rand($urandom_range(1, 12), 2);
      repeat (30) begin ld_valid = 1'($urandom); ld_data = 8'($urandom); rnd_cpu(); cyc(); end
    end

    go = 0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", nerr);
    $fatal(1);
  end
endmodule
